// File: rtl/game_tick_scheduler_if.sv
// game_tick_scheduler_if: control pulses in, tick/state/level out.
`default_nettype none

interface game_tick_scheduler_if #(
  parameter int LVL_W = 4
);
  logic             start_in;
  logic             pause_in;
  logic             stop_in;
  logic             speed_up;
  logic             tick_out;
  logic [1:0]       state_out;
  logic [LVL_W-1:0] level_out;

  modport master (
    output start_in, pause_in, stop_in, speed_up,
    input  tick_out, state_out, level_out
  );

  modport slave (
    input  start_in, pause_in, stop_in, speed_up,
    output tick_out, state_out, level_out
  );
endinterface

`default_nettype wire

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: one-cycle game tick every period(level) cycles,
// with start/pause/stop control and a saturating speed level.
`default_nettype none

module game_tick_scheduler #(
  parameter int BASE_PERIOD = 6_250_000,
  parameter int STEP_PERIOD = 500_000,
  parameter int MIN_PERIOD  = 1_250_000,
  parameter int MAX_LEVEL   = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  game_tick_scheduler_if.slave  bus
);

  localparam int LVL_W = $clog2(MAX_LEVEL + 1);
  localparam int CNT_W = $clog2(BASE_PERIOD + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] counter, counter_next;
  logic [CNT_W-1:0] period_cur, period_next;
  logic [LVL_W-1:0] level, level_next, level_inc;
  logic             tick, tick_next;

  // Reduction is compared against the headroom before subtracting so the
  // period can never wrap below zero.
  function automatic logic [CNT_W-1:0] period_of(input logic [LVL_W-1:0] lvl);
    logic [63:0] red;
    red = 64'(lvl) * 64'(STEP_PERIOD);
    if (red + 64'(MIN_PERIOD) >= 64'(BASE_PERIOD))
      period_of = CNT_W'(MIN_PERIOD);
    else
      period_of = CNT_W'(64'(BASE_PERIOD) - red);
  endfunction

  always_comb begin
    level_inc = level;
    if (bus.speed_up && (level < LVL_W'(MAX_LEVEL)))
      level_inc = level + LVL_W'(1);
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    period_next  = period_cur;
    level_next   = level;
    tick_next    = 1'b0;

    case (state)
      IDLE: begin
        counter_next = '0;
        level_next   = '0;
        period_next  = CNT_W'(BASE_PERIOD);
        if (bus.start_in)
          state_next = RUN;
      end
      RUN: begin
        level_next = level_inc;
        // Wrap reloads with the post-speed_up level so a same-cycle bump counts.
        if (counter == period_cur - CNT_W'(1)) begin
          counter_next = '0;
          tick_next    = 1'b1;
          period_next  = period_of(level_inc);
        end else begin
          counter_next = counter + CNT_W'(1);
        end
        if (bus.pause_in)
          state_next = PAUSED;
      end
      PAUSED: begin
        level_next = level_inc;
        if (bus.pause_in)
          state_next = RUN;
      end
      default: state_next = IDLE;
    endcase

    if (bus.stop_in) begin
      state_next   = IDLE;
      counter_next = '0;
      level_next   = '0;
      period_next  = CNT_W'(BASE_PERIOD);
      tick_next    = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      counter    <= '0;
      period_cur <= CNT_W'(BASE_PERIOD);
      level      <= '0;
      tick       <= 1'b0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      period_cur <= period_next;
      level      <= level_next;
      tick       <= tick_next;
    end
  end

  assign bus.tick_out  = tick;
  assign bus.state_out = state;
  assign bus.level_out = level;

endmodule

`default_nettype wire

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: scenario tables with a per-edge scoreboard.
`default_nettype none

module tb_game_tick_scheduler;

  localparam int LVL_W = 3;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  game_tick_scheduler_if #(.LVL_W(LVL_W)) bus ();

  game_tick_scheduler #(
    .BASE_PERIOD(10),
    .STEP_PERIOD(2),
    .MIN_PERIOD (4),
    .MAX_LEVEL  (5)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  typedef struct {int sc; int e; int start; int pause; int stop; int speed; int rst;} stim_t;
  typedef struct {int sc; int e;} tick_t;
  typedef struct {int sc; int e; int state; int level;} chk_t;
  typedef struct {int sc; int e; int tick; int state; int level;} exp_t;

  stim_t stims[$];
  tick_t ticks[$];
  chk_t  chks[$];
  exp_t  sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic run_sc(input int sc, input int last_edge);
    exp_t x;
    @(negedge clk_in);
    rst_in = 1'b1;
    bus.start_in = 1'b0; bus.pause_in = 1'b0; bus.stop_in = 1'b0; bus.speed_up = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check($sformatf("s%0d reset tick", sc), int'(bus.tick_out), 0);
    check($sformatf("s%0d reset state", sc), int'(bus.state_out), 0);
    check($sformatf("s%0d reset level", sc), int'(bus.level_out), 0);

    for (int e = 0; e <= last_edge; e++) begin
      @(negedge clk_in);
      rst_in = 1'b0;
      bus.start_in = 1'b0; bus.pause_in = 1'b0; bus.stop_in = 1'b0; bus.speed_up = 1'b0;
      foreach (stims[i]) if (stims[i].sc == sc && stims[i].e == e) begin
        if (stims[i].start != 0) bus.start_in = 1'b1;
        if (stims[i].pause != 0) bus.pause_in = 1'b1;
        if (stims[i].stop  != 0) bus.stop_in  = 1'b1;
        if (stims[i].speed != 0) bus.speed_up = 1'b1;
        if (stims[i].rst   != 0) rst_in       = 1'b1;
      end
      x = '{sc, e, 0, -1, -1};
      foreach (ticks[i]) if (ticks[i].sc == sc && ticks[i].e == e) x.tick = 1;
      foreach (chks[i]) if (chks[i].sc == sc && chks[i].e == e) begin
        x.state = chks[i].state;
        x.level = chks[i].level;
      end
      sb.push_back(x);

      @(posedge clk_in); #1;
      x = sb.pop_front();
      check($sformatf("s%0d e%0d tick", x.sc, x.e), int'(bus.tick_out), x.tick);
      if (x.state >= 0)
        check($sformatf("s%0d e%0d state", x.sc, x.e), int'(bus.state_out), x.state);
      if (x.level >= 0)
        check($sformatf("s%0d e%0d level", x.sc, x.e), int'(bus.level_out), x.level);
    end
    rst_in = 1'b0;
  endtask

  initial begin
    bus.start_in = 1'b0; bus.pause_in = 1'b0; bus.stop_in = 1'b0; bus.speed_up = 1'b0;

    // Stimulus: {scenario, edge, start, pause, stop, speed, rst}
    stims = '{
      '{1, 0, 1,0,0,0,0}, '{1,15, 1,0,0,0,0},
      '{2, 0, 1,0,0,0,0}, '{2, 3, 0,1,0,0,0}, '{2,10, 0,1,0,0,0},
      '{3, 0, 1,0,0,0,0}, '{3, 5, 0,0,0,1,0}, '{3,20, 0,0,0,1,0},
      '{3,21, 0,0,0,1,0}, '{3,22, 0,0,0,1,0}, '{3,23, 0,0,0,1,0}, '{3,24, 0,0,0,1,0},
      '{4, 0, 1,0,0,0,0}, '{4, 4, 0,0,0,1,0}, '{4, 9, 0,0,1,0,0}, '{4,20, 1,0,0,0,0},
      '{5, 0, 1,0,0,0,0}, '{5, 3, 0,0,0,1,0}, '{5, 6, 0,0,0,0,1}, '{5,12, 1,0,1,0,0},
      '{6, 0, 1,0,0,0,0}, '{6,10, 0,0,0,1,0},
      '{7, 0, 1,0,0,0,0}, '{7,10, 0,0,1,0,0}, '{7,11, 0,1,0,1,0}
    };
    // Edges at which tick_out must be high; low everywhere else.
    ticks = '{
      '{1,10}, '{1,20}, '{1,30},
      '{2,17}, '{2,27},
      '{3,10}, '{3,18}, '{3,26}, '{3,30}, '{3,34}, '{3,38},
      '{4,30},
      '{6,10}, '{6,18}
    };
    // {scenario, edge, state (-1 skip), level (-1 skip)}
    chks = '{
      '{1, 1, 1, 0}, '{1,15, 1,-1}, '{1,31, 1, 0},
      '{2, 3, 2,-1}, '{2, 9, 2,-1}, '{2,10, 1,-1},
      '{3, 6, 1, 1}, '{3,23,-1, 5}, '{3,24,-1, 5}, '{3,39, 1, 5},
      '{4, 5, 1, 1}, '{4, 9, 0, 0}, '{4,19, 0,-1}, '{4,20, 1, 0},
      '{5, 3, 1, 1}, '{5, 6, 0, 0}, '{5,12, 0, 0}, '{5,20, 0,-1},
      '{6,10, 1, 1},
      '{7,10, 0, 0}, '{7,11, 0, 0}, '{7,13, 0,-1}
    };

    run_sc(1, 31);
    run_sc(2, 28);
    run_sc(3, 39);
    run_sc(4, 31);
    run_sc(5, 20);
    run_sc(6, 19);
    run_sc(7, 13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
